// File: rtl/debounce_pkg.sv
// Shared FSM state encoding for the multi-channel debouncer.
// Used by debounce_chan and debounce_multi.
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ZERO  = 2'b00,
    WAIT0 = 2'b01,
    ONE   = 2'b10,
    WAIT1 = 2'b11
  } state_e;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, level/tick FSMD, optional hold counter.
// Long-press tick is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1),
  parameter int LP_CYCLES   = 50000000,
  parameter int LP_W        = $clog2(LP_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic long_tick
);

  localparam logic [CNT_W-1:0] DB_LOAD = CNT_W'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || LP_CYCLES < 1 || LP_W < 1)
  begin : g_bad_param
    $error("debounce_chan: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   sw_s;
  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   to_one;
  logic                   to_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], sw};
  end

  assign sw_s    = sync[SYNC_STAGES-1];
  assign to_one  = (state == WAIT1) && sw_s && (cnt == '0);
  assign to_zero = (state == WAIT0) && !sw_s && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ZERO;
      cnt       <= '0;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      unique case (state)
        ZERO: begin
          if (sw_s) begin
            state <= WAIT1;
            cnt   <= DB_LOAD;
          end
        end
        WAIT1: begin
          if (!sw_s) begin
            state <= ZERO;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= ONE;
            db_level  <= 1'b1;
            rise_tick <= 1'b1;
          end
        end
        ONE: begin
          if (!sw_s) begin
            state <= WAIT0;
            cnt   <= DB_LOAD;
          end
        end
        WAIT0: begin
          if (sw_s) begin
            state <= ONE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= ZERO;
            db_level  <= 1'b0;
            fall_tick <= 1'b1;
          end
        end
        default: state <= ZERO;
      endcase
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CYCLES);
  localparam logic [LP_W-1:0] LP_PRE = LP_W'(LP_CYCLES - 1);

  logic [LP_W-1:0] hold;
  logic            held;

  // WAIT0 still counts: the press is not over until the fall completes
  assign held = (state == ONE) || (state == WAIT0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      long_tick <= 1'b0;
    end else begin
      long_tick <= 1'b0;
      if (to_one || to_zero) begin
        hold <= '0;
      end else if (held && hold != LP_MAX) begin
        hold      <= hold + 1'b1;
        long_tick <= (hold == LP_PRE);
      end
    end
  end
`else
  logic unused_tr;
  assign unused_tr = to_one ^ to_zero;
  assign long_tick = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch debouncer: NCH independent channels plus a registered any_tick.
// Optional long-press ticks via DEBOUNCE_LONGPRESS_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = $clog2(DB_CYCLES + 1),
  parameter int LP_CYCLES   = 50000000,
  parameter int LP_W        = $clog2(LP_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] sw,
  output logic [NCH-1:0] db_level,
  output logic [NCH-1:0] rise_tick,
  output logic [NCH-1:0] fall_tick,
  output logic [NCH-1:0] long_tick,
  output logic           any_tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W),
      .LP_CYCLES   (LP_CYCLES),
      .LP_W        (LP_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw        (sw[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .long_tick (long_tick[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) any_tick <= 1'b0;
    else          any_tick <= |(rise_tick | fall_tick);
  end

endmodule
